uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between N packet sources. Each source is a byte stream with valid/ready and a last marker.
- Grants whole packets round-robin and forwards the granted stream onto the transmitter's data/enable/ready interface.
- Sits between on-chip producers (debug, status, command-response) and the TX path of the UART top level.

---
 rtl/uart_tx_arb_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_if.sv | 22 ++
 rtl/uart_tx_arbiter_rr.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared constants for the UART TX packet arbiter: state encoding, header tag, width helpers.
package uart_tx_arb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_XFER = 2'd2;

   localparam logic [3:0] LP_HDR_TAG = 4'hA;

   function automatic int f_clog2(input int x);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < x) r = i + 1;
      end
      return r;
   endfunction

   // Register width for x distinct values; never narrower than one bit.
   function automatic int f_width(input int x);
      return (x <= 1) ? 1 : f_clog2(x);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester streams and transmitter handshake of the UART TX arbiter; slave = arbiter side.
interface uart_tx_arbiter_if #(parameter int N = 4);
   logic [N-1:0]   req_vld_i;
   logic [8*N-1:0] req_data_i;
   logic [N-1:0]   req_last_i;
   logic [N-1:0]   req_rdy_o;
   logic [7:0]     tx_data_o;
   logic           tx_en_o;
   logic           tx_rdy_i;
   logic [N-1:0]   grant_o;
   logic           busy_o;

   modport slave (
      input  req_vld_i, req_data_i, req_last_i, tx_rdy_i,
      output req_rdy_o, tx_data_o, tx_en_o, grant_o, busy_o
   );

   modport master (
      output req_vld_i, req_data_i, req_last_i, tx_rdy_i,
      input  req_rdy_o, tx_data_o, tx_en_o, grant_o, busy_o
   );
endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first requester above i_ptr (wrapping), one-hot plus index.
module rr_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = f_width(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx
);

   logic w_found;
   int   w_k;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_k     = 0;
      for (int i = 1; i <= N; i++) begin
         w_k = (int'(i_ptr) + i) % N;
         if (!w_found && i_req[w_k]) begin
            w_found    = 1'b1;
            o_gnt[w_k] = 1'b1;
            o_idx      = IW'(w_k);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter between N byte streams.
// Optional channel header byte per grant: define UART_TX_ARB_HDR_EN.
module uart_tx_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter int         N         = 4,
   parameter int         MAX_BURST = 64,
   parameter logic [3:0] HDR_TAG   = LP_HDR_TAG
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus
);

   // state   | meaning
   // --------+-----------------------------------------------
   // IDLE    | no owner; pick next requester round-robin
   // HDR     | send {HDR_TAG, index} before the granted stream
   // XFER    | pass granted stream through to the transmitter

   localparam int            IW     = f_width(N);
   localparam int            CW     = f_width(MAX_BURST + 1);
   localparam logic [CW:0]   LP_MAX = (CW + 1)'(MAX_BURST);

   logic [1:0]    r_state;
   logic [N-1:0]  r_grant;
   logic [IW-1:0] r_idx;
   logic [IW-1:0] r_ptr;
   logic [CW-1:0] r_cnt;

   logic [N-1:0]  w_arb_gnt;
   logic [IW-1:0] w_arb_idx;
   logic          w_vld_g;
   logic          w_last_g;
   logic [7:0]    w_data_g;
   logic          w_xfer;
   logic          w_burst_end;

   rr_arbiter #(.N(N), .IW(IW)) u_rr (
      .i_req (bus.req_vld_i),
      .i_ptr (r_ptr),
      .o_gnt (w_arb_gnt),
      .o_idx (w_arb_idx)
   );

   assign w_vld_g     = bus.req_vld_i[r_idx];
   assign w_last_g    = bus.req_last_i[r_idx];
   assign w_data_g    = bus.req_data_i[int'(r_idx)*8 +: 8];
   assign w_xfer      = (r_state == ST_XFER) && w_vld_g && bus.tx_rdy_i;
   // Counter never holds MAX_BURST: the byte that would reach it ends the grant.
   assign w_burst_end = (MAX_BURST != 0) && (({1'b0, r_cnt} + (CW + 1)'(1)) == LP_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_idx   <= '0;
         r_ptr   <= IW'(N - 1);
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|bus.req_vld_i) begin
                  r_grant <= w_arb_gnt;
                  r_idx   <= w_arb_idx;
                  r_ptr   <= w_arb_idx;
`ifdef UART_TX_ARB_HDR_EN
                  r_state <= ST_HDR;
`else
                  r_state <= ST_XFER;
`endif
               end
            end
`ifdef UART_TX_ARB_HDR_EN
            ST_HDR: begin
               if (bus.tx_rdy_i) r_state <= ST_XFER;
            end
`endif
            ST_XFER: begin
               if (w_xfer) begin
                  if (w_last_g || w_burst_end) begin
                     r_state <= ST_IDLE;
                     r_grant <= '0;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.tx_en_o   = 1'b0;
      bus.tx_data_o = 8'h00;
      bus.req_rdy_o = '0;
      case (r_state)
`ifdef UART_TX_ARB_HDR_EN
         ST_HDR: begin
            bus.tx_en_o   = 1'b1;
            bus.tx_data_o = {HDR_TAG, 4'(r_idx)};
         end
`endif
         ST_XFER: begin
            bus.tx_en_o   = w_vld_g;
            bus.tx_data_o = w_data_g;
            if (w_xfer) bus.req_rdy_o = r_grant;
         end
         default: ;
      endcase
   end

   assign bus.grant_o = r_grant;
   assign bus.busy_o  = (r_state == ST_HDR) || (r_state == ST_XFER);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N=4, MAX_BURST=4): cycle vector table plus packet-level scenarios.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.N(N)) bus();

   uart_tx_arbiter #(.N(N), .MAX_BURST(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0]  vld;
      logic [31:0] data;
      logic [3:0]  last;
      logic        rdy;
      logic        en;
      logic [7:0]  txd;
      logic [3:0]  gnt;
      logic [3:0]  rrdy;
      logic        busy;
   } vec_t;

   vec_t tv[$];

   logic [7:0] q_dat[N][$];
   logic       q_lst[N][$];
   logic [7:0] log_b[$];
   int         log_g[$];
   int         log_t[$];
   logic [7:0] exp_b[$];
   int         exp_g[$];
   int         cyc;
   logic       hold_v;
   logic [7:0] hold_d;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int oh2i(input logic [3:0] v);
      for (int k = 0; k < N; k++) if (v[k]) return k;
      return -1;
   endfunction

   function automatic void add_pkt(input int s, input logic [7:0] first, input int len);
      for (int i = 0; i < len; i++) begin
         q_dat[s].push_back(first + 8'(i));
         q_lst[s].push_back(i == len - 1);
      end
   endfunction

   function automatic void exp_run(input int g, input logic [7:0] first, input int len);
`ifdef UART_TX_ARB_HDR_EN
      exp_b.push_back(8'hA0 + 8'(g));
      exp_g.push_back(g);
`endif
      for (int i = 0; i < len; i++) begin
         exp_b.push_back(first + 8'(i));
         exp_g.push_back(g);
      end
   endfunction

   task automatic clear_all();
      for (int k = 0; k < N; k++) begin
         q_dat[k].delete();
         q_lst[k].delete();
      end
      log_b.delete(); log_g.delete(); log_t.delete();
      exp_b.delete(); exp_g.delete();
      cyc = 0;
      hold_v = 1'b0;
   endtask

   task automatic drive_srcs();
      for (int k = 0; k < N; k++) begin
         bus.req_vld_i[k]         = (q_dat[k].size() != 0);
         bus.req_data_i[8*k +: 8] = (q_dat[k].size() != 0) ? q_dat[k][0] : 8'h00;
         bus.req_last_i[k]        = (q_lst[k].size() != 0) ? q_lst[k][0] : 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1'b0;
      bus.req_vld_i = '0; bus.req_data_i = '0; bus.req_last_i = '0; bus.tx_rdy_i = 1'b1;
      clear_all();
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   // One clock: drive at posedge+1, sample at negedge, consume accepted bytes after the edge.
   task automatic step(input logic rdy);
      logic [3:0] rr;
      drive_srcs();
      bus.tx_rdy_i = rdy;
      @(negedge clk);
      if (!rdy) chk("rdy_gated", bus.req_rdy_o, 0);
      if (hold_v && bus.tx_en_o) chk("hold_data", bus.tx_data_o, hold_d);
      hold_v = bus.tx_en_o && !rdy;
      hold_d = bus.tx_data_o;
      if (bus.tx_en_o && rdy) begin
         log_b.push_back(bus.tx_data_o);
         log_g.push_back(oh2i(bus.grant_o));
         log_t.push_back(cyc);
      end
      rr = bus.req_rdy_o;
      @(posedge clk); #1;
      cyc++;
      for (int k = 0; k < N; k++) begin
         if (rr[k]) begin
            void'(q_dat[k].pop_front());
            void'(q_lst[k].pop_front());
         end
      end
   endtask

   task automatic run(input string nm, input int lo, input int hi, input int max);
      int  i;
      logic pend;
      i = 0;
      pend = 1'b1;
      while (pend && i < max) begin
         step(!(i >= lo && i < hi));
         i++;
         pend = bus.busy_o;
         for (int k = 0; k < N; k++) if (q_dat[k].size() != 0) pend = 1'b1;
      end
      if (pend) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_timeout: got %0d cycles expected completion", nm, i);
      end
   endtask

   task automatic compare(input string nm);
      int n;
      chk({nm, "_len"}, log_b.size(), exp_b.size());
      n = (log_b.size() < exp_b.size()) ? log_b.size() : exp_b.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_byte%0d", nm, i), log_b[i], exp_b[i]);
         chk($sformatf("%s_gnt%0d", nm, i), log_g[i], exp_g[i]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_vld_i = '0; bus.req_data_i = '0; bus.req_last_i = '0; bus.tx_rdy_i = 1'b1;
      clear_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_en",   bus.tx_en_o,   0);
      chk("rst_data", bus.tx_data_o, 0);
      chk("rst_gnt",  bus.grant_o,   0);
      chk("rst_rrdy", bus.req_rdy_o, 0);
      chk("rst_busy", bus.busy_o,    0);
      @(posedge clk); #2;
      rst = 1'b1;

`ifdef UART_TX_ARB_HDR_EN
      tv.push_back('{4'b0100, 32'h005A_0000, 4'b0100, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0});
      tv.push_back('{4'b0100, 32'h005A_0000, 4'b0100, 1'b0, 1'b1, 8'hA2, 4'b0100, 4'b0000, 1'b1});
      tv.push_back('{4'b0100, 32'h005A_0000, 4'b0100, 1'b1, 1'b1, 8'hA2, 4'b0100, 4'b0000, 1'b1});
      tv.push_back('{4'b0100, 32'h005A_0000, 4'b0100, 1'b1, 1'b1, 8'h5A, 4'b0100, 4'b0100, 1'b1});
      tv.push_back('{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0});
`else
      tv.push_back('{4'b0010, 32'h0000_1100, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0});
      tv.push_back('{4'b0010, 32'h0000_1100, 4'b0000, 1'b1, 1'b1, 8'h11, 4'b0010, 4'b0010, 1'b1});
      tv.push_back('{4'b1010, 32'hFF00_2200, 4'b1000, 1'b1, 1'b1, 8'h22, 4'b0010, 4'b0010, 1'b1});
      tv.push_back('{4'b1000, 32'hFF00_3300, 4'b1000, 1'b1, 1'b0, 8'h33, 4'b0010, 4'b0000, 1'b1});
      tv.push_back('{4'b1010, 32'hFF00_3300, 4'b1010, 1'b1, 1'b1, 8'h33, 4'b0010, 4'b0010, 1'b1});
      tv.push_back('{4'b1000, 32'hFF00_0000, 4'b1000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0});
      tv.push_back('{4'b1000, 32'hFF00_0000, 4'b1000, 1'b0, 1'b1, 8'hFF, 4'b1000, 4'b0000, 1'b1});
      tv.push_back('{4'b1000, 32'hFF00_0000, 4'b1000, 1'b1, 1'b1, 8'hFF, 4'b1000, 4'b1000, 1'b1});
      tv.push_back('{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0});
`endif
      @(posedge clk); #1;
      for (int i = 0; i < tv.size(); i++) begin
         bus.req_vld_i  = tv[i].vld;
         bus.req_data_i = tv[i].data;
         bus.req_last_i = tv[i].last;
         bus.tx_rdy_i   = tv[i].rdy;
         @(negedge clk);
         chk($sformatf("v%0d_en", i),   bus.tx_en_o,   tv[i].en);
         chk($sformatf("v%0d_data", i), bus.tx_data_o, tv[i].txd);
         chk($sformatf("v%0d_gnt", i),  bus.grant_o,   tv[i].gnt);
         chk($sformatf("v%0d_rrdy", i), bus.req_rdy_o, tv[i].rrdy);
         chk($sformatf("v%0d_busy", i), bus.busy_o,    tv[i].busy);
         @(posedge clk); #1;
      end

      // Fairness: 0 and 2 alternate, source 0 first, one idle cycle between grants.
      do_reset();
      add_pkt(0, 8'h01, 2); add_pkt(0, 8'h03, 2);
      add_pkt(2, 8'h21, 2); add_pkt(2, 8'h23, 2);
      exp_run(0, 8'h01, 2); exp_run(2, 8'h21, 2); exp_run(0, 8'h03, 2); exp_run(2, 8'h23, 2);
      run("fair", 0, 0, 100);
      compare("fair");
      if (log_t.size() > 0)
         chk("fair_span", log_t[log_t.size()-1] - log_t[0], exp_b.size() - 1 + 3);

      // Backpressure mid-packet for five cycles.
      do_reset();
      add_pkt(1, 8'h31, 4);
      exp_run(1, 8'h31, 4);
      run("bp", 3, 8, 100);
      compare("bp");

      // Burst cap of 4 with source 3 waiting.
      do_reset();
      add_pkt(0, 8'hB0, 10);
      add_pkt(3, 8'hC0, 2); add_pkt(3, 8'hC2, 2);
      exp_run(0, 8'hB0, 4); exp_run(3, 8'hC0, 2); exp_run(0, 8'hB4, 4);
      exp_run(3, 8'hC2, 2); exp_run(0, 8'hB8, 2);
      run("burst", 0, 0, 200);
      compare("burst");

      // Reset after two data bytes of a five-byte packet.
      do_reset();
      add_pkt(0, 8'hD0, 5);
      for (int i = 0; i < 20 && log_b.size() < exp_b.size() + 2; i++) begin
`ifdef UART_TX_ARB_HDR_EN
         if (i == 0) exp_run(0, 8'hD0, 0);
`endif
         step(1'b1);
      end
      chk("rstmid_pre", q_dat[0].size(), 3);
      rst = 1'b0;
      #1;
      chk("rstmid_en",   bus.tx_en_o,   0);
      chk("rstmid_data", bus.tx_data_o, 0);
      chk("rstmid_gnt",  bus.grant_o,   0);
      chk("rstmid_rrdy", bus.req_rdy_o, 0);
      chk("rstmid_busy", bus.busy_o,    0);
      #3;
      rst = 1'b1;
      log_b.delete(); log_g.delete(); log_t.delete();
      exp_b.delete(); exp_g.delete();
      add_pkt(1, 8'hE0, 1);
      @(posedge clk); #1;
      exp_run(0, 8'hD2, 3); exp_run(1, 8'hE0, 1);
      run("rstmid", 0, 0, 100);
      compare("rstmid");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
